// File: rtl/multicycle_multiplier.sv
// ---------------------------------------------------------------------------
// multicycle_multiplier
//   Iterative RV32M multiplier (MUL / MULH / MULHSU / MULHU). Operands are
//   converted to magnitudes on accept and multiplied with a radix-2
//   shift-add loop, one bit per cycle. The sign is reapplied to the
//   2W-bit product when the loop finishes. The selected half is then
//   registered and presented with a one-cycle Done_o pulse.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for Start_i; operands are latched on the accept edge
//   BUSY  | one shift-add step per cycle, DATA_WIDTH cycles in total
//   DONE  | Result_o valid and Done_o high for one cycle; Stall_o is low
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   asynchronous, active-high; forces IDLE
//   Start_i     in   multiply request (qualified upstream)
//   Funct3_i    in   00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   Rs1_Data_i  in   multiplicand
//   Rs2_Data_i  in   multiplier
//   Result_o    out  selected product half, registered
//   Done_o      out  result valid for writeback (one cycle)
//   Busy_o      out  high while the iteration runs
//   Stall_o     out  holds PC/regfile while a product is being formed
// ---------------------------------------------------------------------------
module multicycle_multiplier #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start_i,
    input  logic [1:0]            Funct3_i,
    input  logic [DATA_WIDTH-1:0] Rs1_Data_i,
    input  logic [DATA_WIDTH-1:0] Rs2_Data_i,
    output logic [DATA_WIDTH-1:0] Result_o,
    output logic                  Done_o,
    output logic                  Busy_o,
    output logic                  Stall_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0]              funct3_q;
    logic                    neg_q;
    logic [DATA_WIDTH-1:0]   mcand_q;
    logic [DATA_WIDTH-1:0]   mplier_q;
    logic [2*DATA_WIDTH-1:0] prod_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic [DATA_WIDTH-1:0]   result_q;

    logic                    accept;
    logic                    last_step;
    logic                    rs1_neg, rs2_neg;
    logic [DATA_WIDTH-1:0]   rs1_mag, rs2_mag;
    logic [DATA_WIDTH:0]     step_sum;
    logic [2*DATA_WIDTH-1:0] step_prod;
    logic [2*DATA_WIDTH-1:0] final_prod;
    logic [DATA_WIDTH-1:0]   final_res;

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state and outputs
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_step = 1'b0;
        Busy_o    = 1'b0;
        Done_o    = 1'b0;
        Stall_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start_i) begin
                    accept  = 1'b1;
                    Stall_o = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                Busy_o  = 1'b1;
                Stall_o = 1'b1;
                if (cnt_q == '0) begin
                    last_step = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                // Stall drops here so the PC advances while the result is written back.
                Done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand conditioning: rs1 is signed for MULH/MULHSU, rs2 only for MULH.
    // Negating -2^(W-1) yields 2^(W-1), which is the correct unsigned magnitude.
    always_comb begin
        rs1_neg = ((Funct3_i == 2'b01) || (Funct3_i == 2'b10)) && Rs1_Data_i[DATA_WIDTH-1];
        rs2_neg = (Funct3_i == 2'b01) && Rs2_Data_i[DATA_WIDTH-1];
        rs1_mag = rs1_neg ? -Rs1_Data_i : Rs1_Data_i;
        rs2_mag = rs2_neg ? -Rs2_Data_i : Rs2_Data_i;
    end

    // One shift-add step. The carry out of the upper-half add is kept and
    // becomes the MSB after the right shift.
    always_comb begin
        step_sum   = {1'b0, prod_q[2*DATA_WIDTH-1:DATA_WIDTH]}
                   + {1'b0, (mplier_q[0] ? mcand_q : {DATA_WIDTH{1'b0}})};
        step_prod  = {step_sum, prod_q[DATA_WIDTH-1:1]};
        final_prod = neg_q ? -step_prod : step_prod;
        final_res  = (funct3_q == 2'b00) ? final_prod[DATA_WIDTH-1:0]
                                         : final_prod[2*DATA_WIDTH-1:DATA_WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            funct3_q <= 2'b00;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                funct3_q <= Funct3_i;
                neg_q    <= rs1_neg ^ rs2_neg;
                mcand_q  <= rs1_mag;
                mplier_q <= rs2_mag;
                prod_q   <= '0;
                cnt_q    <= CNT_WIDTH'(DATA_WIDTH - 1);
            end else if (state_q == BUSY) begin
                prod_q   <= step_prod;
                mplier_q <= mplier_q >> 1;
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_WIDTH'(1);
                end
                if (last_step) begin
                    result_q <= final_res;
                end
            end
        end
    end

    assign Result_o = result_q;

endmodule

// File: tb/tb_multicycle_multiplier.sv
// Directed bench for multicycle_multiplier: mid-operation reset, each funct3
// variant with hand-computed products, latency/stall/busy timing and a
// held Start_i request.
module tb_multicycle_multiplier;

    logic        clk;
    logic        reset;
    logic        Start_i;
    logic [1:0]  Funct3_i;
    logic [31:0] Rs1_Data_i;
    logic [31:0] Rs2_Data_i;
    logic [31:0] Result_o;
    logic        Done_o;
    logic        Busy_o;
    logic        Stall_o;

    int n_pass  = 0;
    int n_total = 0;

    multicycle_multiplier #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .Start_i    (Start_i),
        .Funct3_i   (Funct3_i),
        .Rs1_Data_i (Rs1_Data_i),
        .Rs2_Data_i (Rs2_Data_i),
        .Result_o   (Result_o),
        .Done_o     (Done_o),
        .Busy_o     (Busy_o),
        .Stall_o    (Stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Launch one operation at a negedge (cycle 0) and follow it to Done_o.
    task automatic run_op(input string tag, input logic [1:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int done_n    = 0;
        int busy_cnt  = 0;
        int stall_bad = 0;
        logic stall_at_done = 1'b1;
        @(negedge clk);
        Funct3_i   = f3;
        Rs1_Data_i = a;
        Rs2_Data_i = b;
        Start_i    = 1'b1;
        #1;
        check({tag, "_stall_c0"}, {31'b0, Stall_o}, 32'd1);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                // Inputs changing after accept must not affect the result.
                Start_i    = 1'b0;
                Funct3_i   = ~f3;
                Rs1_Data_i = ~a;
                Rs2_Data_i = b ^ 32'h5A5A_5A5A;
            end
            busy_cnt += int'(Busy_o);
            if (Done_o) begin
                done_n        = n;
                stall_at_done = Stall_o;
                break;
            end
            if (!Stall_o) stall_bad++;
        end
        check({tag, "_done_cycle"}, done_n, 32'd33);
        check({tag, "_result"}, Result_o, exp);
        check({tag, "_stall_done"}, {31'b0, stall_at_done}, 32'd0);
        check({tag, "_busy_cycles"}, busy_cnt, 32'd32);
        check({tag, "_stall_gaps"}, stall_bad, 32'd0);
        @(negedge clk);
        check({tag, "_done_1cyc"}, {31'b0, Done_o}, 32'd0);
        check({tag, "_hold"}, Result_o, exp);
    endtask

    initial begin
        int done_pulses;
        int first_done;
        logic stall34, busy34, busy35;

        reset      = 1'b1;
        Start_i    = 1'b0;
        Funct3_i   = 2'b00;
        Rs1_Data_i = '0;
        Rs2_Data_i = '0;
        repeat (2) @(negedge clk);
        check("rst_result", Result_o, 32'd0);
        check("rst_done", {31'b0, Done_o}, 32'd0);
        check("rst_busy", {31'b0, Busy_o}, 32'd0);
        reset = 1'b0;

        // Reset asserted mid-BUSY aborts with no Done_o.
        @(negedge clk);
        Funct3_i   = 2'b11;
        Rs1_Data_i = 32'h1234_5678;
        Rs2_Data_i = 32'h0000_0100;
        Start_i    = 1'b1;
        @(negedge clk);
        Start_i = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_pre", {31'b0, Busy_o}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", {31'b0, Busy_o}, 32'd0);
        check("abort_stall", {31'b0, Stall_o}, 32'd0);
        check("abort_result", Result_o, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            done_pulses += int'(Done_o);
        end
        check("abort_no_done", done_pulses, 32'd0);
        check("abort_result_after", Result_o, 32'd0);

        run_op("mul_7xm3",     2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulhu_ff",     2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mul_ff",       2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("mulh_min2",    2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mulh_minx1",   2'b01, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
        run_op("mulhsu_m1",    2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu_zero",  2'b10, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000);
        run_op("mulh_pos",     2'b01, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003);

        // Start_i held high for 40 cycles: one pulse at 33, re-accept at 34.
        @(negedge clk);
        Funct3_i    = 2'b00;
        Rs1_Data_i  = 32'd3;
        Rs2_Data_i  = 32'd5;
        Start_i     = 1'b1;
        done_pulses = 0;
        first_done  = 0;
        stall34 = 1'b0;
        busy34  = 1'b1;
        busy35  = 1'b0;
        for (int n = 1; n < 40; n++) begin
            @(negedge clk);
            #1;
            if (Done_o) begin
                done_pulses++;
                if (first_done == 0) first_done = n;
            end
            if (n == 34) begin
                stall34 = Stall_o;
                busy34  = Busy_o;
            end
            if (n == 35) busy35 = Busy_o;
        end
        Start_i = 1'b0;
        check("hold_pulses", done_pulses, 32'd1);
        check("hold_first_done", first_done, 32'd33);
        check("hold_result", Result_o, 32'd15);
        check("hold_stall34", {31'b0, stall34}, 32'd1);
        check("hold_busy34", {31'b0, busy34}, 32'd0);
        check("hold_busy35", {31'b0, busy35}, 32'd1);
        first_done = 0;
        for (int n = 40; n < 80; n++) begin
            @(negedge clk);
            if (Done_o) begin
                first_done = n;
                break;
            end
        end
        check("hold_second_done", first_done, 32'd67);
        check("hold_second_result", Result_o, 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
